io_irq_servicer: RTL and testbench

- Avalon-MM master that services a single-bit PIO input peripheral with a level-sensitive IRQ (data reg at word address 0, irq-mask reg at word address 2).
- On irq, reads the data register and masks the IRQ off, then hands the sample to fabric logic over a valid/ready event port.
- Re-arms the mask only after the input is seen low, so a held input does not produce an interrupt storm.
- Sits between the game-control fabric and the IO controller PIO, replacing CPU interrupt handling for robot button/sensor events.

---
 rtl/io_pio_pkg.sv | 19 +
 rtl/avm_single_xfer.sv | 43 ++++
 rtl/io_irq_servicer.sv | 131 +++++++++++++
 tb/tb_io_irq_servicer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pio_pkg.sv
// Shared definitions for the PIO interrupt servicer.
// Slave register map and servicer FSM state encoding.
package io_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_RD_DATA  = 3'd2,
    ST_MASK_OFF = 3'd3,
    ST_PUSH     = 3'd4,
    ST_WAIT_GAP = 3'd5,
    ST_POLL     = 3'd6,
    ST_REARM    = 3'd7
  } state_t;

endpackage

// File: rtl/avm_single_xfer.sv
// Single Avalon-MM transfer engine: holds one read or write until
// waitrequest is low, then pulses done and returns readdata.
//   req/wr/addr/wdata : transfer request, held stable by the sequencer
//   done/rdata        : completion strobe and read data of that cycle
//   avm_*             : Avalon-MM master signals
module avm_single_xfer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  // Bus stays quiet while reset is held and for the release cycle,
  // so reset drops the strobes asynchronously.
  logic live_q;
  logic active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  assign active        = req & live_q;
  assign avm_read      = active & ~wr;
  assign avm_write     = active & wr;
  assign avm_address   = active ? addr : 2'd0;
  assign avm_writedata = (active & wr) ? wdata : '0;
  assign done          = active & ~avm_waitrequest;
  assign rdata         = avm_readdata;

endmodule

// File: rtl/io_irq_servicer.sv
// Services a PIO input IRQ: read data, mask IRQ, emit event, poll until
// the input is low, then re-arm. Ports: Avalon-MM master, event port.
module io_irq_servicer
  import io_pio_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 16,
  parameter int MASK_ON  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              irq,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              event_valid,
  output logic              event_data,
  input  logic              event_ready,
  output logic [15:0]       event_count,
  output logic              busy
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
  localparam logic [DATA_W-1:0] MASK_VAL = DATA_W'(MASK_ON);

  state_t state_q;
  state_t state_d;
  logic [7:0]  gap_q;
  logic        data_q;
  logic [15:0] cnt_q;

  logic              req;
  logic              wr;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              unused_rd;

  assign unused_rd = ^rdata[DATA_W-1:1];

  always_comb begin
    req   = 1'b0;
    wr    = 1'b0;
    addr  = PIO_ADDR_DATA;
    wdata = '0;
    unique case (state_q)
      ST_INIT, ST_REARM: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = PIO_ADDR_MASK;
        wdata = MASK_VAL;
      end
      ST_RD_DATA, ST_POLL: begin
        req  = 1'b1;
        addr = PIO_ADDR_DATA;
      end
      ST_MASK_OFF: begin
        req  = 1'b1;
        wr   = 1'b1;
        addr = PIO_ADDR_MASK;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:     if (done) state_d = ST_IDLE;
      ST_IDLE:     if (irq) state_d = ST_RD_DATA;
      ST_RD_DATA:  if (done) state_d = ST_MASK_OFF;
      ST_MASK_OFF: if (done) state_d = ST_PUSH;
      ST_PUSH:     if (event_ready) state_d = ST_WAIT_GAP;
      ST_WAIT_GAP: if (gap_q == GAP_LAST) state_d = ST_POLL;
      ST_POLL: begin
        if (done) state_d = rdata[0] ? ST_WAIT_GAP : ST_REARM;
      end
      ST_REARM:    if (done) state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      gap_q   <= 8'd0;
      data_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      // Counter restarts on every entry into the gap.
      if (state_q == ST_WAIT_GAP && gap_q != GAP_LAST)
        gap_q <= gap_q + 8'd1;
      else
        gap_q <= 8'd0;
      if (state_q == ST_RD_DATA && done)
        data_q <= rdata[0];
      if (state_q == ST_PUSH && event_ready)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign event_valid = (state_q == ST_PUSH);
  assign event_data  = data_q;
  assign event_count = cnt_q;
  assign busy        = (state_q != ST_IDLE);

  avm_single_xfer #(
    .DATA_W(DATA_W)
  ) u_xfer (
    .clk             (clk),
    .rst_n           (reset_n),
    .req             (req),
    .wr              (wr),
    .addr            (addr),
    .wdata           (wdata),
    .done            (done),
    .rdata           (rdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

endmodule

// File: tb/tb_io_irq_servicer.sv
// Self-checking bench for io_irq_servicer with a PIO slave model.
// Table-driven cycle vectors plus hand sequences for multi-cycle cases.
module tb_io_irq_servicer;

  localparam int POLL_GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        wq;
  logic        event_valid;
  logic        event_data;
  logic        event_ready;
  logic [15:0] event_count;
  logic        busy;

  logic in_port;
  logic irq_force;
  logic mask = 1'b0;
  int   wr_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign irq = (in_port & mask) | irq_force;
  assign avm_readdata = (avm_address == 2'd2) ? {31'd0, mask}
                                              : {31'd0, in_port};

  always @(posedge clk) begin
    if (avm_write && !wq) begin
      wr_cnt <= wr_cnt + 1;
      if (avm_address == 2'd2) mask <= avm_writedata[0];
    end
  end

  io_irq_servicer #(
    .DATA_W(32), .POLL_GAP(POLL_GAP), .MASK_ON(1)
  ) dut (
    .clk             (clk),
    .reset_n         (rst_n),
    .irq             (irq),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (wq),
    .event_valid     (event_valid),
    .event_data      (event_data),
    .event_ready     (event_ready),
    .event_count     (event_count),
    .busy            (busy)
  );

  typedef struct {
    logic        in_port;
    logic        ready;
    logic        wq;
    logic        busy;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        v;
    logic        d;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic i, logic r, logic q, logic b, logic rd, logic wr,
    logic [1:0] a, logic [31:0] wd, logic v, logic d, logic [15:0] c);
    vec_t t;
    t.in_port = i; t.ready = r; t.wq = q; t.busy = b;
    t.rd = rd; t.wr = wr; t.addr = a; t.wd = wd;
    t.v = v; t.d = d; t.c = c;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input int i);
    in_port     = tbl[i].in_port;
    event_ready = tbl[i].ready;
    wq          = tbl[i].wq;
    @(negedge clk);
    chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
    chk($sformatf("row%0d.read", i), 32'(avm_read), 32'(tbl[i].rd));
    chk($sformatf("row%0d.write", i), 32'(avm_write), 32'(tbl[i].wr));
    chk($sformatf("row%0d.addr", i), 32'(avm_address), 32'(tbl[i].addr));
    chk($sformatf("row%0d.wdata", i), avm_writedata, tbl[i].wd);
    chk($sformatf("row%0d.valid", i), 32'(event_valid), 32'(tbl[i].v));
    chk($sformatf("row%0d.data", i), 32'(event_data), 32'(tbl[i].d));
    chk($sformatf("row%0d.count", i), 32'(event_count), 32'(tbl[i].c));
    step();
  endtask

  // Leaves at the negedge where the signal is seen (0 rd, 1 wr, 2 valid).
  task automatic wait_for(input int which, input int limit, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      hit = (which == 0) ? avm_read :
            (which == 1) ? avm_write : event_valid;
      if (!hit) begin
        step();
        n++;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait%0d: timeout after %0d cycles, expected event", which, n);
    end
  endtask

  int n;
  int wc0;
  logic ok;

  initial begin
    // in rdy wq | busy rd wr addr wdata valid data count
    // reset release and first irq service
    tbl.push_back(mk(0,1,0, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 1,0,1,2,1, 0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0, 0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0, 1,1,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0, 1,0,1,2,0, 0,1,0));
    tbl.push_back(mk(1,1,0, 1,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,1,0, 1,0,0,0,0, 0,1,1));
    // read stalled 5 cycles; readdata low until the release cycle
    tbl.push_back(mk(1,1,1, 0,0,0,0,0, 0,1,1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,1,1, 1,1,0,0,0, 0,1,1));
    tbl.push_back(mk(1,1,0, 1,1,0,0,0, 0,1,1));
    tbl.push_back(mk(1,1,0, 1,0,1,2,0, 0,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,0,0, 1,1,1));
    // irq falls while in RD_DATA: a 0 is delivered
    tbl.push_back(mk(1,1,0, 0,0,0,0,0, 0,1,2));
    tbl.push_back(mk(0,1,0, 1,1,0,0,0, 0,1,2));
    tbl.push_back(mk(0,1,0, 1,0,1,2,0, 0,0,2));
    tbl.push_back(mk(0,1,0, 1,0,0,0,0, 1,0,2));
    tbl.push_back(mk(0,1,0, 1,0,0,0,0, 0,0,3));

    rst_n = 1'b0;
    in_port = 1'b0;
    irq_force = 1'b0;
    event_ready = 1'b1;
    wq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 1);
    chk("rst.read", 32'(avm_read), 0);
    chk("rst.write", 32'(avm_write), 0);
    chk("rst.addr", 32'(avm_address), 0);
    chk("rst.wdata", avm_writedata, 0);
    chk("rst.valid", 32'(event_valid), 0);
    chk("rst.data", 32'(event_data), 0);
    chk("rst.count", 32'(event_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_row(i);

    // input held high: periodic polls, no re-arm
    wc0 = wr_cnt;
    wait_for(0, 40, n);
    chk("poll1.gap", 32'(n + 1), 32'(POLL_GAP));
    chk("poll1.addr", 32'(avm_address), 0);
    step();
    wait_for(0, 40, n);
    chk("poll2.gap", 32'(n), 32'(POLL_GAP));
    step();
    in_port = 1'b0;
    chk("held.no_write", 32'(wr_cnt), 32'(wc0));
    wait_for(1, 40, n);
    chk("rearm.gap", 32'(n), 32'(POLL_GAP + 1));
    chk("rearm.addr", 32'(avm_address), 2);
    chk("rearm.wdata", avm_writedata, 1);
    step();
    chk("rearm.busy", 32'(busy), 0);
    chk("rearm.mask", 32'(mask), 1);

    for (int i = 8; i < 17; i++) run_row(i);

    // consumer stalls 20 cycles; extra irq pulses must be ignored
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_port = k[0];
      irq_force = (k >= 5 && k < 9);
      @(negedge clk);
      if (!event_valid || !event_data || avm_read || avm_write) ok = 1'b0;
      step();
    end
    chk("push.hold", 32'(ok), 1);
    chk("push.count_held", 32'(event_count), 1);
    irq_force = 1'b0;
    in_port = 1'b0;
    event_ready = 1'b1;
    @(negedge clk);
    chk("push.valid", 32'(event_valid), 1);
    step();
    chk("push.count", 32'(event_count), 2);
    chk("push.drop", 32'(event_valid), 0);
    wait_for(1, 60, n);
    chk("rearm2.addr", 32'(avm_address), 2);
    step();
    chk("rearm2.busy", 32'(busy), 0);
    chk("rearm2.count", 32'(event_count), 2);

    for (int i = 17; i < 22; i++) run_row(i);
    wait_for(1, 60, n);
    chk("rearm3.wdata", avm_writedata, 1);
    step();
    chk("rearm3.busy", 32'(busy), 0);

    // reset during MASK_OFF with the write stalled
    in_port = 1'b1;
    step();
    step();
    wq = 1'b1;
    @(negedge clk);
    chk("mrst.pre_write", 32'(avm_write), 1);
    chk("mrst.pre_addr", 32'(avm_address), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.write", 32'(avm_write), 0);
    chk("mrst.addr", 32'(avm_address), 0);
    chk("mrst.busy", 32'(busy), 1);
    chk("mrst.count", 32'(event_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wq = 1'b0;
    in_port = 1'b0;
    @(negedge clk);
    chk("mrst.quiet", 32'(avm_write), 0);
    step();
    @(negedge clk);
    chk("mrst.init_write", 32'(avm_write), 1);
    chk("mrst.init_addr", 32'(avm_address), 2);
    chk("mrst.init_wdata", avm_writedata, 1);
    step();
    chk("mrst.idle", 32'(busy), 0);

    // count wrap
    force dut.cnt_q = 16'hFFFF;
    step();
    release dut.cnt_q;
    chk("wrap.pre", 32'(event_count), 32'hFFFF);
    in_port = 1'b1;
    wait_for(2, 10, n);
    chk("wrap.latency", 32'(n), 3);
    in_port = 1'b0;
    step();
    chk("wrap.count", 32'(event_count), 0);
    wait_for(1, 60, n);
    step();
    chk("wrap.idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
